// File: rtl/kmeans_pass_ctrl.sv
// kmeans_pass_ctrl: sequences K-means passes over a byte-wide RGB image memory
// Ports: clk/reset (async, active high); start begins a run, busy/strb/iter_cnt report it.
//   mem_addr/mem_rd_en/mem_data: byte reads, data returns the cycle after mem_rd_en.
//   pix_valid/pix_rgb/pix_last/pix_ready: pixel handoff to the assign/accumulate datapath.
//   upd_start/upd_done/upd_changed: centroid-update phase handshake.
//   err: update timeout flag, live only when KMEANS_PASS_CTRL_TIMEOUT_EN is defined.
module kmeans_pass_ctrl #(
   parameter int NUM_PIXELS  = 4096,
   parameter int ADDR_W      = 14,
   parameter int MAX_ITER    = 16,
   parameter int ITER_W      = 5,
   parameter int UPD_TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [7:0]        mem_data,
   output logic              pix_valid,
   output logic [23:0]       pix_rgb,
   output logic              pix_last,
   input  logic              pix_ready,
   output logic              upd_start,
   input  logic              upd_done,
   input  logic              upd_changed,
   output logic              busy,
   output logic              strb,
   output logic [ITER_W-1:0] iter_cnt,
   output logic              err
);
   localparam int PW = $clog2(NUM_PIXELS + 1);
   if ((1 << ADDR_W) < 3 * NUM_PIXELS || MAX_ITER < 1 || MAX_ITER >= (1 << ITER_W) || UPD_TIMEOUT < 1) begin : g_bad_param
      $error("kmeans_pass_ctrl: inconsistent parameters");
   end
   typedef enum logic [2:0] {IDLE, FETCH, PRESENT, UPDATE, CHECK, DONE} state_t;
   state_t            state_q, state_d;
   logic [PW-1:0]     p_q, p_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [1:0]        ph_q, ph_d;
   logic [23:0]       rgb_q, rgb_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic              chg_q, chg_d;
   logic              ust_q, ust_d;
   logic              is_last;
   logic              tmo_hit;
   assign is_last = p_q == PW'(NUM_PIXELS - 1);
`ifdef KMEANS_PASS_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(UPD_TIMEOUT + 1);
   logic [TW-1:0] tmo_q, tmo_d;
   logic          err_q, err_d;
   // the counter is zero on the first UPDATE cycle, so the limit hits after exactly UPD_TIMEOUT cycles
   assign tmo_hit = state_q == UPDATE && !upd_done && tmo_q == TW'(UPD_TIMEOUT - 1);
   always_comb begin
      tmo_d = (state_q == UPDATE) ? tmo_q + TW'(1) : '0;
      err_d = (state_q == IDLE && start) ? 1'b0 : (tmo_hit ? 1'b1 : err_q);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_d;
      end
   end
   assign err = err_q;
`else
   assign tmo_hit = 1'b0;
   assign err     = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      ptr_d   = ptr_q;
      ph_d    = ph_q;
      rgb_d   = rgb_q;
      iter_d  = iter_q;
      chg_d   = chg_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = FETCH;
            p_d     = '0;
            ptr_d   = '0;
            ph_d    = '0;
            iter_d  = '0;
         end
         // phases 0..2 issue reads, phases 1..3 capture the byte read one cycle earlier
         FETCH: begin
            ph_d  = ph_q + 2'd1;
            ptr_d = (ph_q != 2'd3) ? ptr_q + ADDR_W'(1) : ptr_q;
            if (ph_q == 2'd1) rgb_d[23:16] = mem_data;
            if (ph_q == 2'd2) rgb_d[15:8] = mem_data;
            if (ph_q == 2'd3) begin
               rgb_d[7:0] = mem_data;
               state_d    = PRESENT;
            end
         end
         PRESENT: if (pix_ready) begin
            state_d = is_last ? UPDATE : FETCH;
            p_d     = is_last ? p_q : p_q + PW'(1);
         end
         UPDATE: if (upd_done) begin
            chg_d   = upd_changed;
            iter_d  = iter_q + ITER_W'(1);
            state_d = CHECK;
         end else if (tmo_hit) state_d = DONE;
         CHECK: if (!chg_q || iter_q == ITER_W'(MAX_ITER)) state_d = DONE;
         else begin
            state_d = FETCH;
            p_d     = '0;
            ptr_d   = '0;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      ust_d = state_d == UPDATE && state_q != UPDATE;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         p_q     <= '0;
         ptr_q   <= '0;
         ph_q    <= '0;
         rgb_q   <= '0;
         iter_q  <= '0;
         chg_q   <= 1'b0;
         ust_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         ptr_q   <= ptr_d;
         ph_q    <= ph_d;
         rgb_q   <= rgb_d;
         iter_q  <= iter_d;
         chg_q   <= chg_d;
         ust_q   <= ust_d;
      end
   end
   assign busy      = state_q != IDLE;
   assign strb      = state_q == DONE;
   assign pix_valid = state_q == PRESENT;
   assign pix_last  = pix_valid && is_last;
   assign mem_rd_en = state_q == FETCH && ph_q != 2'd3;
   assign mem_addr  = ptr_q;
   assign pix_rgb   = rgb_q;
   assign upd_start = ust_q;
   assign iter_cnt  = iter_q;
endmodule
